pipe_hazard_ctrl: RTL and testbench

- Parametrised pipeline hazard and sequencing controller for the RV32I core.
- Holds a decode register plus an instruction history of depth FWD_DEPTH+1 (EX, MEM, WB, ...), each entry tagged with a valid bit.
- Generates prioritised multi-stage forwarding selects, load-use stalls of configurable length, and multi-cycle flushes after taken branches/jumps.
- Sits between fetch and the execute-stage muxes. Decode of ALU/memory controls stays in the per-stage decoders.

---
 rtl/pipe_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller: a decode register plus a valid-tagged instruction history
// that drives EX forwarding selects, load-use stalls and post-branch flush windows.
module pipe_hazard_ctrl #(
    parameter int  FWD_DEPTH    = 2,
    parameter int  LOAD_LATENCY = 1,
    parameter int  FLUSH_CYCLES = 2,
    localparam int SEL_W        = $clog2(FWD_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_i,
    input  logic             inst_valid_i,
    input  logic             branch_taken_i,
    output logic             stall_o,
    output logic             flush_o,
    output logic [SEL_W-1:0] fwd_a_sel_o,
    output logic [SEL_W-1:0] fwd_b_sel_o,
    output logic [31:0]      ex_inst_o,
    output logic             ex_valid_o
);
    localparam int CNT_MAX = (LOAD_LATENCY > FLUSH_CYCLES) ? LOAD_LATENCY : FLUSH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_REGREG = 7'b0110011;

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               idVld_q, idVld_d;
    logic [31:0]        idInst_q, idInst_d;
    logic [FWD_DEPTH:0] histVld_q, histVld_d;
    logic [31:0]        histInst_q [FWD_DEPTH+1];
    logic [31:0]        histInst_d [FWD_DEPTH+1];
    logic               loadUse;

    function automatic logic writesRd(input logic vld, input logic [6:0] op, input logic [4:0] rd);
        return vld && (op != OP_BRANCH) && (op != OP_STORE) && (rd != 5'd0);
    endfunction

    function automatic logic usesRs1(input logic [6:0] op);
        return (op != OP_LUI) && (op != OP_AUIPC) && (op != OP_JAL);
    endfunction

    function automatic logic usesRs2(input logic [6:0] op);
        return (op == OP_REGREG) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    always_comb begin
        loadUse = histVld_q[0] && (histInst_q[0][6:0] == OP_LOAD) && (histInst_q[0][11:7] != 5'd0)
                  && idVld_q
                  && ((usesRs1(idInst_q[6:0]) && (idInst_q[19:15] == histInst_q[0][11:7]))
                   || (usesRs2(idInst_q[6:0]) && (idInst_q[24:20] == histInst_q[0][11:7])));
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idVld_d       = inst_valid_i;
        idInst_d      = inst_valid_i ? inst_i : 32'h0;
        histVld_d[0]  = idVld_q;
        histInst_d[0] = idInst_q;
        for (int k = 1; k <= FWD_DEPTH; k++) begin
            histVld_d[k]  = histVld_q[k-1];
            histInst_d[k] = histInst_q[k-1];
        end

        // A taken branch wins over everything, including an in-progress stall.
        if (branch_taken_i) begin
            state_d       = FLUSH;
            cnt_d         = CNT_W'(FLUSH_CYCLES - 1);
            idVld_d       = 1'b0;
            idInst_d      = 32'h0;
            histVld_d[0]  = 1'b0;
            histInst_d[0] = 32'h0;
        end else begin
            case (state_q)
                RUN: begin
                    if (loadUse) begin
                        idVld_d       = idVld_q;
                        idInst_d      = idInst_q;
                        histVld_d[0]  = 1'b0;
                        histInst_d[0] = 32'h0;
                        if (LOAD_LATENCY > 1) begin
                            state_d = STALL;
                            cnt_d   = CNT_W'(LOAD_LATENCY - 1);
                        end
                    end
                end
                STALL: begin
                    idVld_d       = idVld_q;
                    idInst_d      = idInst_q;
                    histVld_d[0]  = 1'b0;
                    histInst_d[0] = 32'h0;
                    cnt_d         = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = RUN;
                end
                FLUSH: begin
                    idVld_d  = 1'b0;
                    idInst_d = 32'h0;
                    if (cnt_q == '0) state_d = RUN;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        stall_o = 1'b0;
        flush_o = (state_q == FLUSH);
        if (!branch_taken_i) begin
            if (state_q == RUN)        stall_o = loadUse;
            else if (state_q == STALL) stall_o = 1'b1;
        end
    end

    // Walk oldest to youngest so the nearest producer overwrites the select last.
    always_comb begin
        fwd_a_sel_o = '0;
        fwd_b_sel_o = '0;
        if (histVld_q[0]) begin
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (writesRd(histVld_q[k], histInst_q[k][6:0], histInst_q[k][11:7])) begin
                    if (usesRs1(histInst_q[0][6:0]) && (histInst_q[k][11:7] == histInst_q[0][19:15]))
                        fwd_a_sel_o = SEL_W'(k);
                    if (usesRs2(histInst_q[0][6:0]) && (histInst_q[k][11:7] == histInst_q[0][24:20]))
                        fwd_b_sel_o = SEL_W'(k);
                end
            end
        end
    end

    assign ex_inst_o  = histInst_q[0];
    assign ex_valid_o = histVld_q[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            idVld_q   <= 1'b0;
            idInst_q  <= 32'h0;
            histVld_q <= '0;
            for (int k = 0; k <= FWD_DEPTH; k++) histInst_q[k] <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idVld_q   <= idVld_d;
            idInst_q  <= idInst_d;
            histVld_q <= histVld_d;
            for (int k = 0; k <= FWD_DEPTH; k++) histInst_q[k] <= histInst_d[k];
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: default instance (depth 2, 1-cycle load stall) and a
// depth-1 / 3-cycle-load instance, driven from vector tables through an expectation queue.
module tb_pipe_hazard_ctrl;
    localparam logic [31:0] ADD1  = 32'h002081B3;  // add  x3,x1,x2
    localparam logic [31:0] ADD2  = 32'h00318233;  // add  x4,x3,x3
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] LW    = 32'h0000A283;  // lw   x5,0(x1)
    localparam logic [31:0] ADD3  = 32'h00728333;  // add  x6,x5,x7
    localparam logic [31:0] ADDI0 = 32'h00108013;  // addi x0,x1,1
    localparam logic [31:0] ADD4  = 32'h00200233;  // add  x4,x0,x2

    typedef struct packed {
        logic        dut;
        logic [31:0] inst;
        logic        vld;
        logic        br;
        logic        stall;
        logic        flush;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        exVld;
        logic [31:0] exInst;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] instA = 32'h0;
    logic        vldA  = 1'b0;
    logic        brA   = 1'b0;
    logic        stallA, flushA, exVldA;
    logic [1:0]  faA, fbA;
    logic [31:0] exInstA;

    logic [31:0] instB = 32'h0;
    logic        vldB  = 1'b0;
    logic        brB   = 1'b0;
    logic        stallB, flushB, exVldB;
    logic [0:0]  faB, fbB;
    logic [31:0] exInstB;

    int   checks = 0;
    int   passes = 0;
    vec_t expQ[$];

    pipe_hazard_ctrl dutA (
        .clk(clk), .rst(rst), .inst_i(instA), .inst_valid_i(vldA), .branch_taken_i(brA),
        .stall_o(stallA), .flush_o(flushA), .fwd_a_sel_o(faA), .fwd_b_sel_o(fbA),
        .ex_inst_o(exInstA), .ex_valid_o(exVldA)
    );

    pipe_hazard_ctrl #(.FWD_DEPTH(1), .LOAD_LATENCY(3), .FLUSH_CYCLES(2)) dutB (
        .clk(clk), .rst(rst), .inst_i(instB), .inst_valid_i(vldB), .branch_taken_i(brB),
        .stall_o(stallB), .flush_o(flushB), .fwd_a_sel_o(faB), .fwd_b_sel_o(fbB),
        .ex_inst_o(exInstB), .ex_valid_o(exVldB)
    );

    function automatic vec_t mkVec(input logic dut, input logic [31:0] inst, input logic vld,
                                   input logic br, input logic stall, input logic flush,
                                   input logic [1:0] fa, input logic [1:0] fb,
                                   input logic exVld, input logic [31:0] exInst);
        vec_t v;
        v.dut = dut; v.inst = inst; v.vld = vld; v.br = br; v.stall = stall; v.flush = flush;
        v.fa = fa; v.fb = fb; v.exVld = exVld; v.exInst = exInst;
        return v;
    endfunction

    task automatic compare(input string tag, input string field, input logic [31:0] act,
                           input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", tag, field, act, exp);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.dut == 1'b0) begin
            instA = v.inst; vldA = v.vld; brA = v.br;
        end else begin
            instB = v.inst; vldB = v.vld; brB = v.br;
        end
        expQ.push_back(v);
    endtask

    task automatic checkOutput(input string tag, input bit atNegedge);
        vec_t e;
        if (atNegedge) @(negedge clk);
        if (expQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL %s.queue: got empty scoreboard, expected an entry", tag);
            return;
        end
        e = expQ.pop_front();
        if (e.dut == 1'b0) begin
            compare(tag, "stall",  {31'b0, stallA}, {31'b0, e.stall});
            compare(tag, "flush",  {31'b0, flushA}, {31'b0, e.flush});
            compare(tag, "fwdA",   {30'b0, faA},    {30'b0, e.fa});
            compare(tag, "fwdB",   {30'b0, fbA},    {30'b0, e.fb});
            compare(tag, "exVld",  {31'b0, exVldA}, {31'b0, e.exVld});
            compare(tag, "exInst", exInstA,         e.exInst);
        end else begin
            compare(tag, "stall",  {31'b0, stallB}, {31'b0, e.stall});
            compare(tag, "flush",  {31'b0, flushB}, {31'b0, e.flush});
            compare(tag, "fwdA",   {31'b0, faB},    {30'b0, e.fa});
            compare(tag, "fwdB",   {31'b0, fbB},    {30'b0, e.fb});
            compare(tag, "exVld",  {31'b0, exVldB}, {31'b0, e.exVld});
            compare(tag, "exInst", exInstB,         e.exInst);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stepV(input string tag, input vec_t v);
        applyStimulus(v);
        checkOutput(tag, 1'b1);
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t tbl [29];
        tbl[0]  = mkVec(0, ADD1,  1, 0, 0, 0, 0, 0, 0, 32'h0);
        tbl[1]  = mkVec(0, ADD2,  1, 0, 0, 0, 0, 0, 0, 32'h0);
        tbl[2]  = mkVec(0, NOP,   1, 0, 0, 0, 0, 0, 1, ADD1);
        tbl[3]  = mkVec(0, ADD1,  1, 0, 0, 0, 1, 1, 1, ADD2);
        tbl[4]  = mkVec(0, NOP,   1, 0, 0, 0, 0, 0, 1, NOP);
        tbl[5]  = mkVec(0, ADD2,  1, 0, 0, 0, 0, 0, 1, ADD1);
        tbl[6]  = mkVec(0, NOP,   1, 0, 0, 0, 0, 0, 1, NOP);
        tbl[7]  = mkVec(0, NOP,   1, 0, 0, 0, 2, 2, 1, ADD2);
        tbl[8]  = mkVec(0, ADD1,  1, 0, 0, 0, 0, 0, 1, NOP);
        tbl[9]  = mkVec(0, ADD1,  1, 0, 0, 0, 0, 0, 1, NOP);
        tbl[10] = mkVec(0, ADD2,  1, 0, 0, 0, 0, 0, 1, ADD1);
        tbl[11] = mkVec(0, LW,    1, 0, 0, 0, 0, 0, 1, ADD1);
        tbl[12] = mkVec(0, ADD3,  1, 0, 0, 0, 1, 1, 1, ADD2);
        tbl[13] = mkVec(0, NOP,   1, 0, 1, 0, 0, 0, 1, LW);
        tbl[14] = mkVec(0, NOP,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        tbl[15] = mkVec(0, NOP,   1, 0, 0, 0, 2, 0, 1, ADD3);
        tbl[16] = mkVec(0, ADDI0, 1, 0, 0, 0, 0, 0, 1, NOP);
        tbl[17] = mkVec(0, ADD4,  1, 0, 0, 0, 0, 0, 1, NOP);
        tbl[18] = mkVec(0, NOP,   1, 0, 0, 0, 0, 0, 1, ADDI0);
        tbl[19] = mkVec(0, NOP,   1, 0, 0, 0, 0, 0, 1, ADD4);
        tbl[20] = mkVec(0, ADD1,  0, 0, 0, 0, 0, 0, 1, NOP);
        tbl[21] = mkVec(0, NOP,   1, 0, 0, 0, 0, 0, 1, NOP);
        tbl[22] = mkVec(0, NOP,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        tbl[23] = mkVec(0, ADD1,  1, 1, 0, 0, 0, 0, 1, NOP);
        tbl[24] = mkVec(0, ADD1,  1, 0, 0, 1, 0, 0, 0, 32'h0);
        tbl[25] = mkVec(0, ADD1,  1, 0, 0, 1, 0, 0, 0, 32'h0);
        tbl[26] = mkVec(0, ADD2,  1, 0, 0, 0, 0, 0, 0, 32'h0);
        tbl[27] = mkVec(0, NOP,   1, 0, 0, 0, 0, 0, 0, 32'h0);
        tbl[28] = mkVec(0, NOP,   1, 0, 0, 0, 0, 0, 1, ADD2);

        #12;
        applyStimulus(mkVec(0, NOP, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        checkOutput("resetA", 1'b0);
        applyStimulus(mkVec(1, NOP, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        checkOutput("resetB", 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 29; i++) stepV($sformatf("row%0d", i), tbl[i]);

        // Taken branch in the load-use cycle, then a second branch that re-arms the flush window.
        stepV("brStall0", mkVec(0, LW,   1, 0, 0, 0, 0, 0, 1, NOP));
        stepV("brStall1", mkVec(0, ADD3, 1, 0, 0, 0, 0, 0, 1, NOP));
        stepV("brStall2", mkVec(0, NOP,  1, 1, 0, 0, 0, 0, 1, LW));
        stepV("brStall3", mkVec(0, ADD1, 1, 0, 0, 1, 0, 0, 0, 32'h0));
        stepV("brStall4", mkVec(0, ADD1, 1, 1, 0, 1, 0, 0, 0, 32'h0));
        stepV("brStall5", mkVec(0, NOP,  1, 0, 0, 1, 0, 0, 0, 32'h0));
        stepV("brStall6", mkVec(0, NOP,  1, 0, 0, 1, 0, 0, 0, 32'h0));
        stepV("brStall7", mkVec(0, NOP,  1, 0, 0, 0, 0, 0, 0, 32'h0));
        stepV("brStall8", mkVec(0, NOP,  1, 0, 0, 0, 0, 0, 0, 32'h0));
        stepV("brStall9", mkVec(0, NOP,  1, 0, 0, 0, 0, 0, 1, NOP));

        // Asynchronous reset while a load sits in EX with a dependent instruction in decode.
        stepV("rstMid0", mkVec(0, LW,   1, 0, 0, 0, 0, 0, 1, NOP));
        stepV("rstMid1", mkVec(0, ADD3, 1, 0, 0, 0, 0, 0, 1, NOP));
        applyStimulus(mkVec(0, NOP, 1, 0, 1, 0, 0, 0, 1, LW));
        checkOutput("rstMid2", 1'b1);
        #2 rst = 1'b0;
        #1;
        applyStimulus(mkVec(0, NOP, 1, 0, 0, 0, 0, 0, 0, 32'h0));
        checkOutput("rstAsync", 1'b0);
        tick();
        rst = 1'b1;
        stepV("rstPost0", mkVec(0, NOP, 1, 0, 0, 0, 0, 0, 0, 32'h0));
        stepV("rstPost1", mkVec(0, NOP, 1, 0, 0, 0, 0, 0, 0, 32'h0));
        stepV("rstPost2", mkVec(0, NOP, 1, 0, 0, 0, 0, 0, 1, NOP));

        // Depth-1 instance: older producers fall out of range; load-use holds for three cycles.
        stepV("depB0", mkVec(1, ADD1, 1, 0, 0, 0, 0, 0, 0, 32'h0));
        stepV("depB1", mkVec(1, NOP,  1, 0, 0, 0, 0, 0, 0, 32'h0));
        stepV("depB2", mkVec(1, ADD2, 1, 0, 0, 0, 0, 0, 1, ADD1));
        stepV("depB3", mkVec(1, LW,   1, 0, 0, 0, 0, 0, 1, NOP));
        stepV("depB4", mkVec(1, ADD3, 1, 0, 0, 0, 0, 0, 1, ADD2));
        stepV("ldB0",  mkVec(1, NOP,  1, 0, 1, 0, 0, 0, 1, LW));
        stepV("ldB1",  mkVec(1, NOP,  1, 0, 1, 0, 0, 0, 0, 32'h0));
        stepV("ldB2",  mkVec(1, NOP,  1, 0, 1, 0, 0, 0, 0, 32'h0));
        stepV("ldB3",  mkVec(1, NOP,  1, 0, 0, 0, 0, 0, 0, 32'h0));
        stepV("ldB4",  mkVec(1, NOP,  1, 0, 0, 0, 0, 0, 1, ADD3));

        if (expQ.size() != 0) begin
            checks++;
            $display("[TB] FAIL drain: got %0d leftover entries, expected 0", expQ.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
